// File: rtl/adas_vehicle_model.sv
// Plant model for the driver-assist controller: control tick generator, speed
// integrator driven by gas/brake, and gap model to a lead vehicle.
module adas_vehicle_model #(
   parameter int TICK_DIV    = 1000,
   parameter int ACCEL       = 2,
   parameter int DECEL       = 4,
   parameter int DRAG        = 1,
   parameter int COAST_TICKS = 4,
   parameter int SPEED_MAX   = 200,
   parameter int CAM_BIAS    = 3,
   parameter int DIST_INIT   = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       gas_i,
   input  logic       brake_i,
   input  logic [7:0] lead_speed_i,
   input  logic       dist_load_i,
   input  logic [7:0] dist_load_val_i,
   output logic       timer_tick_o,
   output logic [7:0] speed_measured_o,
   output logic [7:0] distance_lidar_o,
   output logic [7:0] distance_cam_o,
   output logic       collision_o,
   output logic [1:0] mode_o
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int CW = (COAST_TICKS > 1) ? $clog2(COAST_TICKS) : 1;
   localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CCNT_MAX = CW'(COAST_TICKS - 1);
   localparam logic [7:0] SPD_MAX = 8'(SPEED_MAX);
   localparam int CAM_RST_I = (DIST_INIT + CAM_BIAS > 255) ? 255 : DIST_INIT + CAM_BIAS;

   typedef enum logic [1:0] {COAST = 2'b00, BRAKE = 2'b01, DRIVE = 2'b10, HOLD = 2'b11} mode_e;

   mode_e         mode_q, mode_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [CW-1:0] ccnt_q, ccnt_d;
   logic          tick_q, tick_d;
   logic [7:0]    speed_q, speed_d;
   logic [7:0]    dist_q, dist_d;
   logic [7:0]    cam_q, cam_d;
   logic          coll_q, coll_d;

   logic [8:0]        spd_inc;
   logic signed [9:0] gap_raw;
   logic [7:0]        gap_clamp;
   logic [9:0]        cam_sum;

   // Tick divider: a tick due while disabled is held, not dropped.
   always_comb begin
      tcnt_d = tcnt_q;
      tick_d = 1'b0;
      if (en_i) begin
         tick_d = (tcnt_q == TCNT_MAX);
         tcnt_d = (tcnt_q == TCNT_MAX) ? '0 : tcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) mode_q <= COAST;
      else        mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      if (tick_q) mode_d = mode_e'({gas_i, brake_i});
   end

   always_comb begin
      speed_d = speed_q;
      ccnt_d  = ccnt_q;
      spd_inc = {1'b0, speed_q} + 9'(ACCEL);
      if (tick_q) begin
         ccnt_d = '0;
         unique case (mode_d)
            DRIVE: speed_d = (spd_inc > {1'b0, SPD_MAX}) ? SPD_MAX : spd_inc[7:0];
            BRAKE: speed_d = (speed_q < 8'(DECEL)) ? 8'd0 : speed_q - 8'(DECEL);
            HOLD:  speed_d = speed_q;
            COAST: begin
               if (ccnt_q == CCNT_MAX)
                  speed_d = (speed_q < 8'(DRAG)) ? 8'd0 : speed_q - 8'(DRAG);
               else
                  ccnt_d = ccnt_q + 1'b1;
            end
         endcase
      end
   end

   // Gap uses the pre-update speed; signed 10 bits covers -255..510.
   always_comb begin
      gap_raw   = $signed({2'b00, dist_q}) + $signed({2'b00, lead_speed_i})
                - $signed({2'b00, speed_q});
      gap_clamp = (gap_raw < 0) ? 8'd0 : (gap_raw > 10'sd255) ? 8'hFF : gap_raw[7:0];
      dist_d    = dist_q;
      coll_d    = coll_q;
      if (dist_load_i) begin
         dist_d = dist_load_val_i;
         coll_d = 1'b0;
      end else if (tick_q) begin
         dist_d = gap_clamp;
         if (gap_clamp == 8'd0) coll_d = 1'b1;
      end
      cam_sum = {2'b00, dist_d} + 10'(CAM_BIAS);
      cam_d   = (cam_sum > 10'd255) ? 8'hFF : cam_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt_q  <= '0;
         ccnt_q  <= '0;
         tick_q  <= 1'b0;
         speed_q <= 8'd0;
         dist_q  <= 8'(DIST_INIT);
         cam_q   <= 8'(CAM_RST_I);
         coll_q  <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         ccnt_q  <= ccnt_d;
         tick_q  <= tick_d;
         speed_q <= speed_d;
         dist_q  <= dist_d;
         cam_q   <= cam_d;
         coll_q  <= coll_d;
      end
   end

   assign timer_tick_o     = tick_q;
   assign speed_measured_o = speed_q;
   assign distance_lidar_o = dist_q;
   assign distance_cam_o   = cam_q;
   assign collision_o      = coll_q;
   assign mode_o           = mode_q;

endmodule

// File: doc/adas_vehicle_model.md
# adas_vehicle_model

Closed-loop plant model for the driver-assist controller: the car side of the controller's interface. It generates the periodic control tick, consumes the controller's gas/brake commands, integrates vehicle speed, and models the gap to a lead vehicle. It drives the controller's `timer_trick_i`, `speed_measured_i`, `distance_lidar_i` and `distance_cam_i` inputs so the controller can be exercised in simulation and on FPGA without a real vehicle.

## Interface
Parameters:
- `TICK_DIV`, 1000: clk cycles per control tick; must be ≥ 2.
- `ACCEL`, 2: speed increment per tick under gas.
- `DECEL`, 4: speed decrement per tick under brake.
- `DRAG`, 1: speed decrement applied once every `COAST_TICKS` coasting ticks.
- `COAST_TICKS`, 4: number of coasting ticks per `DRAG` step; must be ≥ 1.
- `SPEED_MAX`, 200: upper speed saturation value; must be ≤ 255.
- `CAM_BIAS`, 3: unsigned offset added to the camera distance.
- `DIST_INIT`, 100: gap value loaded at reset.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `en_i` in 1: run enable. When 0, the tick counter and all state freeze.
- `gas_i` in 1: gas command from the controller.
- `brake_i` in 1: brake command from the controller.
- `lead_speed_i` in 8: lead vehicle speed, same units as speed.
- `dist_load_i` in 1: one-cycle pulse that loads a new gap value.
- `dist_load_val_i` in 8: gap value to load.
- `timer_tick_o` out 1: one-cycle tick pulse to the controller.
- `speed_measured_o` out 8: current vehicle speed.
- `distance_lidar_o` out 8: current gap.
- `distance_cam_o` out 8: gap plus `CAM_BIAS`, saturated.
- `collision_o` out 1: sticky flag, set when the gap hits 0.

## Operation
- **Tick divider:** counter `tcnt` counts 0..TICK_DIV-1 while `en_i`=1, then wraps to 0.
  - `timer_tick_o` is registered high for exactly one cycle, in the cycle after `tcnt`=TICK_DIV-1.
  - With `en_i`=0, `tcnt` holds and no tick is issued.
- **Update event:** at the clock edge where `timer_tick_o`=1, sample `gas_i`/`brake_i`, then update speed and gap.
- **Speed FSM** (state recorded per tick from {gas,brake}, exposed for debug):
  - DRIVE (10): speed = min(speed+ACCEL, SPEED_MAX). Compute in 9 bits before saturating.
  - BRAKE (01): speed = max(speed-DECEL, 0). No underflow wrap.
  - HOLD (11): speed unchanged.
  - COAST (00): `ccnt` increments. When `ccnt` reaches COAST_TICKS-1, speed = max(speed-DRAG, 0) and `ccnt` returns to 0.
  - Any non-COAST tick clears `ccnt`.
- **Gap:** dist_next = dist + lead_speed_i − speed_old, where speed_old is the pre-update speed.
  - Compute as signed 10 bits; clamp to 0..255.
  - If the clamped result is 0, set `collision_o`. It stays set until reset or `dist_load_i`.
- **Distance load:** `dist_load_i`=1 loads `dist_load_val_i` into the gap and clears `collision_o`.
  - Takes priority over a same-cycle tick gap update.
  - The speed update still happens on that tick.
  - Works when `en_i`=0.
- **Sensor outputs:**
  - `distance_lidar_o` = gap register.
  - `distance_cam_o` = min(gap + CAM_BIAS, 255), registered and updated together with the gap.
- **Reset values:** `tcnt`=0, `ccnt`=0, `timer_tick_o`=0, `speed_measured_o`=0, `distance_lidar_o`=DIST_INIT, `distance_cam_o`=min(DIST_INIT+CAM_BIAS,255), `collision_o`=0.
  - Reset asserted mid-tick aborts the period; counting restarts from 0.

## Timing
- First `timer_tick_o` comes TICK_DIV cycles after the first enabled cycle following reset release.
- Ticks then repeat every TICK_DIV enabled cycles.
- Speed, gap and camera outputs change one cycle after the `timer_tick_o` pulse, i.e. they are visible the cycle after the update edge.
- The gas/brake values used are those present during the tick cycle. The controller's response to tick N is therefore applied at tick N+1.
- `dist_load_i` takes effect on the next edge; outputs update one cycle later.
- `en_i` deassertion in the cycle the tick is due suppresses that tick until re-enabled. No tick is lost or duplicated.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench parameters: TICK_DIV=4, ACCEL=2, DECEL=4, DRAG=1, COAST_TICKS=4, SPEED_MAX=10, CAM_BIAS=3, DIST_INIT=100.
- **Reset and tick spacing:** release reset, `en_i`=1 → ticks at cycles 4, 8, 12; speed 0; lidar 100; cam 103; collision 0.
- **Accelerate and saturate:** gas=1, brake=0 for 6 ticks → speed 2, 4, 6, 8, 10, 10.
- **Brake, hold, floor:** from speed 10, brake 2 ticks → 6, 2. Both for 1 tick → 2. Brake 1 tick → 0, not 254.
- **Coast:** from speed 10, {0,0} for 8 ticks → speed 10 for 3 ticks, 9 on tick 4, 8 on tick 8. A gas tick mid-sequence restarts the count.
- **Gap and collision:** lead=0, speed 10, gap 25 → gap 15, 5, 0, with `collision_o`=1 and cam 3. Then `dist_load_i` with 60 → gap 60, cam 63, collision 0.
- **Enable and reset mid-operation:** `en_i`=0 for 10 cycles mid-period → no ticks, outputs frozen; the tick resumes after the remaining count. `rst_n`=0 mid-period → all outputs return to reset values.
